// File: rtl/oreg_arbiter_pkg.sv
// oreg_pkg: shared widths, device indices and command-buffer entry type for the oreg bus
package oreg_pkg;
  localparam int INST_W = 12;
  localparam int WEN_W = 8;
  localparam int DEV_ALU = 0;
  localparam int DEV_ROTARY = 1;
  localparam int DEV_LEDBANK = 2;
  localparam int DEV_VGA = 3;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [WEN_W-1:0] wen;
    logic lock;
  } oreg_cmd_t;
  function automatic logic multi_hot(input logic [WEN_W-1:0] w);
    return (w & (w - WEN_W'(1))) != '0;
  endfunction
endpackage

// File: rtl/oreg_arbiter_if.sv
// oreg_arbiter_if: requester command/ready bus plus the registered peripheral output bus
interface oreg_arbiter_if #(parameter int NREQ = 2);
  import oreg_pkg::*;
  logic [NREQ*INST_W-1:0] req_inst;
  logic [NREQ*WEN_W-1:0] req_wen;
  logic [NREQ-1:0] req_lock;
  logic [NREQ-1:0] req_ready;
  logic [INST_W-1:0] oreg;
  logic [WEN_W-1:0] oreg_wen;
  modport master (output req_inst, req_wen, req_lock, input req_ready, oreg, oreg_wen);
  modport slave (input req_inst, req_wen, req_lock, output req_ready, oreg, oreg_wen);
endinterface

// File: rtl/oreg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from last_grant+1
module rr_pick #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);
  int w_j;
  // Scan farthest-first so the nearest match after i_last is the one left standing
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j = 0;
    for (int i = NREQ; i >= 1; i--) begin
      w_j = int'(i_last) + i;
      w_j = w_j >= NREQ ? w_j - NREQ : w_j;
      if (i_req[w_j]) begin
        o_gnt = '0;
        o_gnt[w_j] = 1'b1;
        o_idx = IW'(w_j);
      end
    end
  end
endmodule

// File: rtl/oreg_arbiter.sv
// oreg_arbiter: per-requester command buffers, round-robin with burst lock onto a registered oreg bus
module oreg_arbiter
  import oreg_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LOCK_TIMEOUT = 15,
  localparam int IW = $clog2(NREQ)
) (
  input  logic clock,
  input  logic reset,
  oreg_arbiter_if.slave bus,
  output logic lock_timeout,
  output logic err_multihot
);
  oreg_cmd_t r_buf [NREQ];
  oreg_cmd_t w_cmd [NREQ];
  oreg_cmd_t w_sel;
  logic [NREQ-1:0] r_full, w_elig, w_gnt, w_ready, w_acc, w_mh;
  logic [IW-1:0] r_last, r_owner, w_idx;
  logic [7:0] r_cnt;
  logic [INST_W-1:0] r_oreg;
  logic [WEN_W-1:0] r_oreg_wen;
  logic r_lock, r_to, r_err, w_any, w_to;
  for (genvar k = 0; k < NREQ; k++) begin : g_req
    assign w_cmd[k] = '{inst: bus.req_inst[k*INST_W +: INST_W], wen: bus.req_wen[k*WEN_W +: WEN_W], lock: bus.req_lock[k]};
    assign w_acc[k] = (|w_cmd[k].wen) & w_ready[k];
    assign w_mh[k] = multi_hot(w_cmd[k].wen);
  end
  // While locked only the owner competes; everyone else simply stays full and not-ready
  assign w_elig = r_lock ? (r_full & (NREQ'(1) << r_owner)) : r_full;
  rr_pick #(.NREQ(NREQ)) u_pick (.i_req(w_elig), .i_last(r_last), .o_gnt(w_gnt), .o_idx(w_idx));
  assign w_any = |w_gnt;
  assign w_sel = r_buf[w_idx];
  assign w_ready = ~r_full | w_gnt;
  assign w_to = r_lock && !r_full[r_owner] && r_cnt == 8'(LOCK_TIMEOUT - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_full <= '0;
      r_last <= IW'(NREQ - 1);
      r_owner <= '0;
      r_lock <= 1'b0;
      r_cnt <= '0;
      r_oreg <= '0;
      r_oreg_wen <= '0;
      r_to <= 1'b0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_acc[i]) begin
          r_buf[i] <= w_cmd[i];
          r_full[i] <= 1'b1;
        end else if (w_gnt[i]) r_full[i] <= 1'b0;
      end
      r_oreg_wen <= w_any ? w_sel.wen : '0;
      if (w_any) begin
        r_oreg <= w_sel.inst;
        r_last <= w_idx;
      end
      if (w_any && w_sel.lock) begin
        r_lock <= 1'b1;
        r_owner <= w_idx;
      end else if (w_any || w_to) r_lock <= 1'b0;
      r_cnt <= (r_lock && !w_any && !w_to) ? r_cnt + 8'd1 : 8'd0;
      r_to <= w_to;
      r_err <= r_err | (|(w_acc & w_mh));
    end
  end
  assign bus.req_ready = w_ready;
  assign bus.oreg = r_oreg;
  assign bus.oreg_wen = r_oreg_wen;
  assign lock_timeout = r_to;
  assign err_multihot = r_err;
endmodule

// File: tb/tb_oreg_arbiter.sv
// tb_oreg_arbiter: table-driven vectors plus hand sequences for bursts, lock and timeout
module tb_oreg_arbiter;
  logic clock, reset, lock_timeout, err_multihot;
  oreg_arbiter_if #(.NREQ(2)) bus();
  oreg_arbiter #(.NREQ(2), .LOCK_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .lock_timeout(lock_timeout), .err_multihot(err_multihot)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  typedef struct {
    logic rst;
    logic [11:0] i0;
    logic [7:0] w0;
    logic [11:0] i1;
    logic [7:0] w1;
    logic chk;
    logic [1:0] rdy;
    logic [11:0] o;
    logic [7:0] w;
    logic e;
  } vec_t;
  typedef struct {
    int cyc;
    logic [11:0] inst;
    logic [7:0] wen;
  } ev_t;
  vec_t tv [25];
  ev_t out_q [$];
  int to_q [$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  always @(negedge clock) begin
    cyc++;
    if (bus.oreg_wen != 0) out_q.push_back('{cyc, bus.oreg, bus.oreg_wen});
    if (lock_timeout) to_q.push_back(cyc);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rst, input logic [11:0] i0, input logic [7:0] w0, input logic l0,
                       input logic [11:0] i1, input logic [7:0] w1, input logic l1);
    reset = rst;
    bus.req_inst = {i1, i0};
    bus.req_wen = {w1, w0};
    bus.req_lock = {l1, l0};
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    out_q.delete();
    to_q.delete();
  endtask
  function automatic logic [11:0] o_inst(input int k);
    return k < out_q.size() ? out_q[k].inst : 12'hFFF;
  endfunction
  function automatic int o_cyc(input int k);
    return k < out_q.size() ? out_q[k].cyc : -1000;
  endfunction
  function automatic int t_cyc(input int k);
    return k < to_q.size() ? to_q[k] : -2000;
  endfunction
  initial begin
    // rst, i0, w0, i1, w1 | chk, ready, oreg, oreg_wen, err  (expected = state before this row's edge)
    tv[0]  = '{1, 12'h123, 8'h04, 12'h222, 8'h02, 0, 2'd0, 12'h000, 8'h00, 0};
    tv[1]  = '{1, 12'h123, 8'h04, 12'h222, 8'h02, 1, 2'd3, 12'h000, 8'h00, 0};
    tv[2]  = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h000, 8'h00, 0};
    tv[3]  = '{0, 12'h123, 8'h04, 12'h000, 8'h00, 1, 2'd3, 12'h000, 8'h00, 0};
    tv[4]  = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h000, 8'h00, 0};
    tv[5]  = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h123, 8'h04, 0};
    tv[6]  = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h123, 8'h00, 0};
    tv[7]  = '{1, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h123, 8'h00, 0};
    tv[8]  = '{0, 12'h111, 8'h01, 12'h222, 8'h02, 1, 2'd3, 12'h000, 8'h00, 0};
    tv[9]  = '{0, 12'h111, 8'h01, 12'h222, 8'h02, 1, 2'd1, 12'h000, 8'h00, 0};
    tv[10] = '{0, 12'h111, 8'h01, 12'h222, 8'h02, 1, 2'd2, 12'h111, 8'h01, 0};
    tv[11] = '{0, 12'h111, 8'h01, 12'h222, 8'h02, 1, 2'd1, 12'h222, 8'h02, 0};
    tv[12] = '{0, 12'h111, 8'h01, 12'h222, 8'h02, 1, 2'd2, 12'h111, 8'h01, 0};
    tv[13] = '{0, 12'h111, 8'h01, 12'h222, 8'h02, 1, 2'd1, 12'h222, 8'h02, 0};
    tv[14] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd2, 12'h111, 8'h01, 0};
    tv[15] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h222, 8'h02, 0};
    tv[16] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h111, 8'h01, 0};
    tv[17] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h111, 8'h00, 0};
    tv[18] = '{0, 12'h0AB, 8'h05, 12'h000, 8'h00, 1, 2'd3, 12'h111, 8'h00, 0};
    tv[19] = '{0, 12'h0CD, 8'h01, 12'h000, 8'h00, 1, 2'd3, 12'h111, 8'h00, 1};
    tv[20] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h0AB, 8'h05, 1};
    tv[21] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h0CD, 8'h01, 1};
    tv[22] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h0CD, 8'h00, 1};
    tv[23] = '{1, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h0CD, 8'h00, 1};
    tv[24] = '{0, 12'h000, 8'h00, 12'h000, 8'h00, 1, 2'd3, 12'h000, 8'h00, 0};
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) begin
      drive(tv[i].rst, tv[i].i0, tv[i].w0, 0, tv[i].i1, tv[i].w1, 0);
      @(negedge clock);
      if (tv[i].chk) begin
        chk($sformatf("row%0d ready", i), bus.req_ready, tv[i].rdy);
        chk($sformatf("row%0d oreg", i), bus.oreg, tv[i].o);
        chk($sformatf("row%0d oreg_wen", i), bus.oreg_wen, tv[i].w);
        chk($sformatf("row%0d err", i), err_multihot, tv[i].e);
        chk($sformatf("row%0d timeout", i), lock_timeout, 0);
      end
      step();
    end
    // back-to-back from one requester: four output cycles with no gap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 12'h301 + 12'(i), 8'h01, 0, 0, 0, 0);
      @(negedge clock);
      chk($sformatf("b2b ready%0d", i), bus.req_ready[0], 1);
      step();
    end
    idle(6);
    chk("b2b count", out_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b inst%0d", k), o_inst(k), 12'h301 + 12'(k));
      chk($sformatf("b2b gap%0d", k), o_cyc(k) - o_cyc(0), k);
    end
    // lock burst holds off a pending requester until the unlocked command
    do_reset();
    drive(0, 12'h010, 8'h08, 1, 12'h2AA, 8'h08, 0);
    step();
    drive(0, 12'h011, 8'h08, 1, 0, 0, 0);
    @(negedge clock);
    chk("lock r1 ready c1", bus.req_ready[1], 0);
    step();
    drive(0, 12'h012, 8'h08, 0, 0, 0, 0);
    @(negedge clock);
    chk("lock r1 ready c2", bus.req_ready[1], 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("lock r1 ready c3", bus.req_ready[1], 0);
    step();
    idle(6);
    chk("lock count", out_q.size(), 4);
    chk("lock out0", o_inst(0), 12'h010);
    chk("lock out1", o_inst(1), 12'h011);
    chk("lock out2", o_inst(2), 12'h012);
    chk("lock out3", o_inst(3), 12'h2AA);
    chk("lock span", o_cyc(3) - o_cyc(0), 3);
    // abandoned lock: timeout pulse 15 cycles after the locked command appears
    do_reset();
    drive(0, 12'h050, 8'h01, 1, 12'h2BB, 8'h02, 0);
    step();
    idle(40);
    chk("to count", out_q.size(), 2);
    chk("to pulses", to_q.size(), 1);
    chk("to out0", o_inst(0), 12'h050);
    chk("to out1", o_inst(1), 12'h2BB);
    chk("to delay", t_cyc(0) - o_cyc(0), 15);
    chk("to r1 next", o_cyc(1) - t_cyc(0), 1);
    // reset mid-lock: no timeout and the pending command is discarded
    do_reset();
    drive(0, 12'h060, 8'h01, 1, 12'h2CC, 8'h02, 0);
    step();
    idle(5);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("rst ready", bus.req_ready, 2'b11);
    chk("rst oreg", bus.oreg, 0);
    step();
    idle(30);
    chk("rst pulses", to_q.size(), 0);
    chk("rst count", out_q.size(), 1);
    chk("rst out0", o_inst(0), 12'h060);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
